// File: rtl/calc2_top.sv
// ============================================================================
// Module   : calc2_top
// Brief    : Multi-port two-operand calculator sharing one ALU via arbitration.
//            Optional macro CALC_OVERFLOW_CHK_EN: add carry / sub borrow -> error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc2_top #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int ARB_RR    = 1
) (
   input  logic                          c_clk,
   input  logic                          reset,
   input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
   input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
   output logic [2*NUM_PORTS-1:0]        out_resp,
   output logic [DATA_W*NUM_PORTS-1:0]   out_data
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int SH_W  = $clog2(DATA_W);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_OP2  = 2'd1;
   localparam logic [1:0] c_WAIT = 2'd2;
   localparam logic [1:0] c_RESP = 2'd3;

   localparam logic [1:0] c_RSP_NONE = 2'd0;
   localparam logic [1:0] c_RSP_OK   = 2'd1;
   localparam logic [1:0] c_RSP_ERR  = 2'd2;

   localparam logic [3:0] c_CMD_ADD = 4'd1;
   localparam logic [3:0] c_CMD_SUB = 4'd2;
   localparam logic [3:0] c_CMD_SHL = 4'd5;
   localparam logic [3:0] c_CMD_SHR = 4'd6;

`ifdef CALC_OVERFLOW_CHK_EN
   localparam logic c_OVF_CHK = 1'b1;
`else
   localparam logic c_OVF_CHK = 1'b0;
`endif

   logic [1:0]        r_state [NUM_PORTS];
   logic [3:0]        r_cmd   [NUM_PORTS];
   logic [DATA_W-1:0] r_op1   [NUM_PORTS];
   logic [DATA_W-1:0] r_op2   [NUM_PORTS];
   logic [1:0]        r_resp  [NUM_PORTS];
   logic [DATA_W-1:0] r_data  [NUM_PORTS];
   logic [IDX_W-1:0]  r_last;

   logic              w_gnt_vld;
   logic [IDX_W-1:0]  w_gnt_idx;
   int                w_p;
   logic [3:0]        w_cmd;
   logic [DATA_W-1:0] w_op1;
   logic [DATA_W-1:0] w_op2;
   logic [DATA_W:0]   w_sum;
   logic [SH_W-1:0]   w_sh;
   logic [DATA_W-1:0] w_res;
   logic [1:0]        w_rsp;

   // Round-robin starts one past the last grant; fixed priority starts at port 0.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      w_p       = 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (ARB_RR != 0) w_p = (int'(r_last) + 1 + i) % NUM_PORTS;
         else             w_p = i;
         if (!w_gnt_vld && r_state[w_p] == c_WAIT) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = IDX_W'(w_p);
         end
      end
   end

   assign w_cmd = r_cmd[w_gnt_idx];
   assign w_op1 = r_op1[w_gnt_idx];
   assign w_op2 = r_op2[w_gnt_idx];
   assign w_sum = {1'b0, w_op1} + {1'b0, w_op2};
   assign w_sh  = w_op2[SH_W-1:0];

   always_comb begin
      w_res = '0;
      w_rsp = c_RSP_OK;
      case (w_cmd)
         c_CMD_ADD: begin
            w_res = w_sum[DATA_W-1:0];
            if (c_OVF_CHK && w_sum[DATA_W]) begin
               w_res = '0;
               w_rsp = c_RSP_ERR;
            end
         end
         c_CMD_SUB: begin
            w_res = w_op1 - w_op2;
            if (c_OVF_CHK && (w_op2 > w_op1)) begin
               w_res = '0;
               w_rsp = c_RSP_ERR;
            end
         end
         c_CMD_SHL: w_res = w_op1 << w_sh;
         c_CMD_SHR: w_res = w_op1 >> w_sh;
         default:   w_rsp = c_RSP_ERR;
      endcase
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         r_last <= IDX_W'(NUM_PORTS - 1);
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_state[p] <= c_IDLE;
            r_cmd[p]   <= '0;
            r_op1[p]   <= '0;
            r_op2[p]   <= '0;
            r_resp[p]  <= c_RSP_NONE;
            r_data[p]  <= '0;
         end
      end else begin
         if (w_gnt_vld) r_last <= w_gnt_idx;
         for (int p = 0; p < NUM_PORTS; p++) begin
            r_resp[p] <= c_RSP_NONE;
            r_data[p] <= '0;
            case (r_state[p])
               c_OP2: begin
                  r_op2[p]   <= req_data_in[DATA_W*p +: DATA_W];
                  r_state[p] <= c_WAIT;
               end
               c_WAIT: begin
                  if (w_gnt_vld && w_gnt_idx == IDX_W'(p)) begin
                     r_resp[p]  <= w_rsp;
                     r_data[p]  <= w_res;
                     r_state[p] <= c_RESP;
                  end
               end
               default: begin
                  // IDLE and RESP both accept a new command
                  if (req_cmd_in[4*p +: 4] != 4'd0) begin
                     r_cmd[p]   <= req_cmd_in[4*p +: 4];
                     r_op1[p]   <= req_data_in[DATA_W*p +: DATA_W];
                     r_state[p] <= c_OP2;
                  end else begin
                     r_state[p] <= c_IDLE;
                  end
               end
            endcase
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
      assign out_resp[2*p +: 2]           = r_resp[p];
      assign out_data[DATA_W*p +: DATA_W] = r_data[p];
   end

endmodule

`default_nettype wire

// File: doc/calc2_top.md
CALC2_TOP -- requirements
Module: calc2_top

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of independent request ports (1..8).
REQ-002 SHALL have parameter DATA_W, default 32: operand/result width (8..64, power of two).
REQ-003 SHALL have parameter ARB_RR, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 highest.
REQ-004 SHALL have port c_clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port req_cmd_in  input  4*NUM_PORTS: per-port command, port p at [4p+3:4p].
REQ-007 SHALL have port req_data_in  input  DATA_W*NUM_PORTS: per-port operand, slice p.
REQ-008 SHALL have port out_resp  output  2*NUM_PORTS: per-port response: 0 none, 1 success, 2 error.
REQ-009 SHALL have port out_data  output  DATA_W*NUM_PORTS: per-port result, valid only when out_resp slice is nonzero.

Function
REQ-010 SHALL decode commands: 0 no-op, 1 add op1+op2, 2 subtract op1-op2, 5 shift left op1 by op2, 6 shift right (logical) op1 by op2; any other nonzero code is invalid.
REQ-011 SHALL, per port, run FSM IDLE -> OP2 -> WAIT -> RESP.
REQ-012 SHALL, in IDLE or RESP, on an edge sampling nonzero cmd, capture cmd and op1 from that port and enter OP2; zero cmd -> IDLE.
REQ-013 SHALL, in OP2, capture op2 on the next edge unconditionally (cmd lines ignored) and enter WAIT.
REQ-014 SHALL ignore cmd/data on a port in OP2 (except op2 capture) or WAIT; no error response for such inputs.
REQ-015 SHALL grant exactly one WAIT port per cycle to the single shared ALU; the granted port's result and response are registered on that edge and the port enters RESP.
REQ-016 SHALL, with ARB_RR=1, search from the port after the last granted port; with ARB_RR=0, grant the lowest-index WAIT port.
REQ-017 SHALL drive a RESP port's out_resp/out_data for exactly one cycle; all other cycles out_resp=0, out_data=0.
REQ-018 SHALL, uncontended, present the response in the cycle following the third edge, the cmd edge being the first (cmd edge k, op2 edge k+1, grant edge k+2).
REQ-019 SHALL, under contention, add exactly one cycle per port granted ahead; round-robin bounds the wait to NUM_PORTS-1 cycles.
REQ-020 SHALL return an invalid command with resp 2, out_data 0, after the same arbitration path.
REQ-021 SHALL use only op2[$clog2(DATA_W)-1:0] as shift amount; upper op2 bits ignored; shifts report resp 1.
REQ-022 SHALL compute add/sub modulo 2^DATA_W.

Reset
REQ-023 SHALL, on reset low, asynchronously force all FSMs to IDLE, out_resp and out_data to 0, round-robin pointer to port NUM_PORTS-1 (so port 0 searches first).
REQ-024 SHALL discard any in-flight command on reset mid-operation; no response is ever issued for it.
REQ-025 SHALL sample the first command on the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with CALC_OVERFLOW_CHK_EN defined, report resp 2 with out_data 0 for add carry-out and for subtract with op2 > op1 (unsigned).
REQ-027 SHALL, without CALC_OVERFLOW_CHK_EN, report resp 1 and the wrapped result for those cases (REQ-022).

Verification
REQ-028 SHALL cover: port0 cmd 1 op1 100, op2 39 -> out_resp[1:0]=1, out_data slice0=139 in the cycle after the third edge.
REQ-029 SHALL cover: port0 cmd 5 op1 1, op2 32'h21 (DATA_W=32) -> result 2 (shift amount 1), resp 1.
REQ-030 SHALL cover: all 4 ports issue cmd 1 op1 1, op2 1 on the same edge, ARB_RR=1 -> resp 1, data 2 on ports 0,1,2,3 in four consecutive cycles.
REQ-031 SHALL cover: port2 cmd 2 op1 5, op2 6 -> resp 2 / data 0 with CALC_OVERFLOW_CHK_EN, resp 1 / data 32'hFFFFFFFF without.
REQ-032 SHALL cover: port1 cmd 4'hF -> resp 2 data 0; port3 reset pulsed while in WAIT -> no response on port3, next command completes normally.
